uart_password_lock: RTL and testbench
=====================================

Name: uart_password_lock

Overview:
- Receive end of the challenge serial link: an 8N1 UART receiver plus a password comparator.
- Deserialises bytes from the uart line and groups them into 8-byte attempts.
- Drives the active-low green LED when an attempt matches PASSWORD, and the active-low red LED while locked.
- Sits inside top, fed directly by the external serial pin.

Parameters:
- CLK_HZ, 12000000, system clock frequency.
- BAUD, 115200, serial bit rate.
- BAUD_P, CLK_HZ/BAUD (=104), clocks per bit, integer-truncated.
- PASSWORD, 64'h3231656d6b636168, expected 8 bytes; byte 0 (bits 7:0) is received first.
- MAX_FAILS, 3, failed attempts before lockout (used only with LOCKOUT_EN).

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- uart  in  1  serial RX line, idle high, asynchronous to clk.
- led_green  out  1  active-low; 0 = unlocked.
- led_red  out  1  active-low; 0 = locked.
- rx_valid  out  1  one-cycle pulse, byte received with a good stop bit.
- rx_data  out  8  last received byte, valid while rx_valid=1, held afterwards.
- frame_err  out  1  one-cycle pulse, stop bit sampled low.

Behaviour:
- Reset values: led_green=1, led_red=0, rx_valid=0, rx_data=0, frame_err=0, FSM=IDLE, byte_cnt=0, fail_cnt=0, unlocked=0, both synchroniser flops=1.
- Input path: uart passes through a 2-flop synchroniser; all logic uses the synchronised signal rx_s.
- Baud counter: wide enough for BAUD_P-1; it is cleared on every FSM state entry.
- IDLE: on rx_s=0, go to START and clear the counter.
- START: at count BAUD_P/2-1 (mid start bit), sample rx_s.
  - rx_s=0: go to DATA with bit index 0.
  - rx_s=1: glitch; return to IDLE, no pulses.
- DATA: every BAUD_P clocks, sample rx_s into shift bit [index], LSB first. After the 8th sample, go to STOP.
- STOP: after BAUD_P clocks, sample rx_s.
  - rx_s=1: next cycle rx_valid=1 and rx_data=byte; return to IDLE.
  - rx_s=0: next cycle frame_err=1; byte discarded; byte_cnt cleared; go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE (no false start on a held-low line).
- Attempt assembly:
  - Each rx_valid stores the byte at slot byte_cnt of a 64-bit buffer, then increments byte_cnt (3-bit counter).
  - On the 8th byte (byte_cnt==7 at rx_valid), compare the full buffer, including the incoming byte, with PASSWORD in that same cycle.
  - The result registers one cycle after the rx_valid pulse. byte_cnt wraps to 0.
- Match: unlocked=1 (sticky until reset); led_green=0, led_red=1.
- Mismatch: unlocked unchanged; fail_cnt increments, saturating.
- Once unlocked, further bytes are still received and pulsed, but the LEDs do not change.
- Reset mid-byte: the FSM returns to IDLE immediately and the partial attempt is lost.

Optional Feature:
- Macro: LOCKOUT_EN.
- Defined:
  - When fail_cnt reaches MAX_FAILS, the block enters permanent lockout until reset.
  - In lockout, the comparator is ignored and unlock is never set.
  - led_red toggles every 2^22 clocks (~0.35 s blink), starting low.
  - The rx path still operates.
- Undefined: unlimited attempts; fail_cnt exists but has no effect; led_red is steady 0 while locked.

Test Plan:
- Correct password: hold uart=1 for 501 cycles after reset, then send 8N1 bytes 68 61 63 6b 6d 65 31 32 at 104 clk/bit.
  - Eight rx_valid pulses with matching rx_data.
  - led_green falls one cycle after the 8th rx_valid; led_red rises.
- Wrong last byte: send 68 61 63 6b 6d 65 31 33 -> led_green stays 1; fail_cnt=1. Then send the correct 8 bytes -> unlock.
- Start glitch: uart low for 20 cycles, then high -> no rx_valid, no frame_err; FSM returns to IDLE. A following correct byte 0x68 is received.
- Framing error: send 0x68 with the stop bit low, then release the line.
  - frame_err pulse, byte_cnt=0, no rx_valid.
  - The next 8 correct bytes unlock.
- Reset mid-byte: assert reset during data bit 4 of byte 3 -> all outputs return to reset values immediately. A full correct sequence afterwards unlocks.
- LOCKOUT_EN: three wrong 8-byte attempts -> led_red starts toggling. A following correct password leaves led_green=1.

Source files
------------

// File: rtl/uart_password_lock.sv
// 8N1 UART receiver feeding an 8-byte password comparator that drives active-low status LEDs.
// Optional LOCKOUT_EN: permanent lockout with a blinking red LED after MAX_FAILS bad attempts.
module uart_password_lock #(
    parameter int          CLK_HZ    = 12000000,
    parameter int          BAUD      = 115200,
    parameter logic [63:0] PASSWORD  = 64'h3231656d6b636168,
    parameter int          MAX_FAILS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart,
    output logic       led_green,
    output logic       led_red,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err
);
    localparam int BAUD_P = CLK_HZ / BAUD;
    localparam int CW     = (BAUD_P > 2) ? $clog2(BAUD_P) : 1;
    localparam int FW     = $clog2(MAX_FAILS + 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_P / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_P - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_nx;
    logic          sync1, rx_s;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    idx, idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          valid_nx, ferr_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= uart;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_data   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            shift     <= shift_nx;
            rx_valid  <= valid_nx;
            frame_err <= ferr_nx;
            if (valid_nx)
                rx_data <= shift;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        shift_nx = shift;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rx_s)
                    state_nx = START;
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt == HALF) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL) begin
                    cnt_nx        = '0;
                    shift_nx[idx] = rx_s;
                    idx_nx        = idx + 1'b1;
                    if (idx == 3'd7)
                        state_nx = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        valid_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line idles so a held-low break is not seen as a start.
                cnt_nx = '0;
                if (rx_s)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    logic [63:0]   attempt;
    logic [63:0]   full_attempt;
    logic [2:0]    byte_cnt;
    logic [FW-1:0] fail_cnt;
    logic          unlocked;
    logic          match;
    logic          locked_out;

    assign full_attempt = {rx_data, attempt[55:0]};
    assign match        = (full_attempt == PASSWORD);

`ifdef LOCKOUT_EN
    assign locked_out = !unlocked && (fail_cnt >= FW'(MAX_FAILS));
`else
    assign locked_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            attempt  <= '0;
            byte_cnt <= '0;
            fail_cnt <= '0;
            unlocked <= 1'b0;
        end else if (frame_err) begin
            byte_cnt <= '0;
        end else if (rx_valid) begin
            attempt[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt                         <= byte_cnt + 1'b1;
            if (byte_cnt == 3'd7) begin
                if (match && !locked_out)
                    unlocked <= 1'b1;
                else if (!match && fail_cnt != FW'(MAX_FAILS))
                    fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end

    assign led_green = ~unlocked;

`ifdef LOCKOUT_EN
    logic [21:0] blink_cnt;
    logic        blink;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (!locked_out) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt)
                blink <= ~blink;
        end
    end

    assign led_red = locked_out ? blink : unlocked;
`else
    assign led_red = unlocked;
`endif

endmodule

// File: tb/tb_uart_password_lock.sv
// Randomised bench for uart_password_lock: a byte/attempt-level model predicts pulses and LED states,
// and one compare process checks the DUT against it every cycle.
module tb_uart_password_lock;
    localparam int BP = 104;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart = 1'b1;
    logic       led_green, led_red, rx_valid, frame_err;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    uart_password_lock dut (
        .clk(clk), .reset(reset), .uart(uart),
        .led_green(led_green), .led_red(led_red),
        .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err)
    );

    int total = 0;
    int bad = 0;
    logic [63:0] pw = 64'h3231656d6b636168;

    typedef struct { bit ferr; logic [7:0] b; } ev_t;
    ev_t        evq[$];
    logic [7:0] m_bytes[8];
    int         m_cnt;
    bit         m_unl;
    int         m_fails;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit m_locked();
`ifdef LOCKOUT_EN
        return !m_unl && m_fails >= 3;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        evq.delete();
        m_cnt = 0;
        m_unl = 1'b0;
        m_fails = 0;
    endtask

    task automatic model_byte(logic [7:0] b);
        bit ok;
        m_bytes[m_cnt] = b;
        if (m_cnt == 7) begin
            ok = 1'b1;
            for (int i = 0; i < 8; i++)
                if (m_bytes[i] !== pw[8*i +: 8]) ok = 1'b0;
            if (ok && !m_locked()) m_unl = 1'b1;
            else if (!ok && m_fails < 3) m_fails++;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // LEDs are checked against the model before it absorbs this cycle's byte,
    // so an unlock must show exactly one cycle after the 8th rx_valid.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("led_green", led_green, !m_unl);
                if (!m_locked()) check("led_red", led_red, m_unl);
                if (rx_valid || frame_err) begin
                    if (evq.size() == 0) begin
                        check("unexpected_pulse", {rx_valid, frame_err}, 2'b00);
                    end else begin
                        ev = evq.pop_front();
                        check("pulse_kind", {rx_valid, frame_err}, ev.ferr ? 2'b01 : 2'b10);
                        if (!ev.ferr) begin
                            check("rx_data", rx_data, ev.b);
                            model_byte(ev.b);
                        end else begin
                            m_cnt = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic drive(bit v, int n);
        uart = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(logic [7:0] b, bit stop = 1'b1);
        evq.push_back('{ferr: !stop, b: b});
        drive(1'b0, BP);
        for (int i = 0; i < 8; i++) drive(b[i], BP);
        drive(stop, BP);
        if (!stop) begin
            drive(1'b0, 50);
            drive(1'b1, 20);
        end
        check("pulse_seen", 64'(evq.size()), 64'd0);
        drive(1'b1, int'($urandom_range(1, 20)));
    endtask

    task automatic send_attempt(logic [63:0] v);
        for (int i = 0; i < 8; i++) send_byte(v[8*i +: 8]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        drive(1'b1, 3);
        reset = 1'b0;
        drive(1'b1, 30);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_green"}, led_green, 1'b1);
        check({tag, "_red"}, led_red, 1'b0);
        check({tag, "_valid"}, rx_valid, 1'b0);
        check({tag, "_data"}, rx_data, 8'h00);
        check({tag, "_ferr"}, frame_err, 1'b0);
    endtask

    initial begin
        logic [63:0] v;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("rst_byte_cnt", 64'(dut.byte_cnt), 64'd0);
        reset = 1'b0;
        drive(1'b1, 501);

        // correct password, then a start glitch and a lone byte while unlocked
        send_attempt(pw);
        check("pw_green", led_green, 1'b0);
        check("pw_red", led_red, 1'b1);
        check("pw_last", rx_data, 8'h32);
        drive(1'b0, 20);
        drive(1'b1, 200);
        check("glitch_data_kept", rx_data, 8'h32);
        send_byte(8'h68);
        check("after_glitch", rx_data, 8'h68);

        // framing error mid-attempt discards the partial attempt
        do_reset();
        send_byte(8'h68);
        send_byte(8'h61);
        send_byte(8'h68, 1'b0);
        check("ferr_byte_cnt", 64'(dut.byte_cnt), 64'd0);
        send_attempt(pw);
        check("ferr_unlock", led_green, 1'b0);

        // reset during data bit 4 of byte 3
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(pw[8*i +: 8]);
        v = pw;
        drive(1'b0, BP);
        for (int i = 0; i < 4; i++) drive(v[24 + i], BP);
        drive(v[28], BP / 2);
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        drive(1'b1, 5);
        reset = 1'b0;
        drive(1'b1, 50);
        send_attempt(pw);
        check("midrst_unlock", led_green, 1'b0);

        // wrong last byte, random wrong attempts, then the password
        do_reset();
        send_attempt(64'h3331656d6b636168);
        check("wrong_green", led_green, 1'b1);
        check("wrong_fails", 64'(dut.fail_cnt), 64'(m_fails));
        for (int k = 0; k < 2; k++) begin
            v = {$urandom, $urandom};
            if (k == 0) v = pw ^ (64'd1 << $urandom_range(0, 63));
            if (v == pw) v[0] = ~v[0];
            send_attempt(v);
        end
        send_attempt(pw);
`ifdef LOCKOUT_EN
        check("lockout_green", led_green, 1'b1);
`else
        check("final_green", led_green, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
